// File: rtl/led_pattern_sequencer_if.sv
// Control and status bundle for the LED pattern sequencer.
// The master drives the run requests; the slave drives the LED and status outputs.
interface led_pattern_sequencer_if;
  logic       start;
  logic       hold;
  logic [1:0] mode;
  logic [7:0] LED8;
  logic       busy;
  logic       done;

  modport master (output start, output hold, output mode,
                  input LED8, input busy, input done);
  modport slave  (input start, input hold, input mode,
                  output LED8, output busy, output done);
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps one of four patterns every DIV clocks, REPEAT cycles per run.
// Supports pause via hold, a one-cycle done pulse, and a synchronous active-low reset.
module led_pattern_sequencer #(
  parameter int DIV    = 4,
  parameter int REPEAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  led_pattern_sequencer_if.slave    io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [16:0] REP_L  = 17'(REPEAT);

  state_t      r_state, w_state_next;
  logic [15:0] r_presc, w_presc_next;
  logic [15:0] r_rep, w_rep_next;
  logic [7:0]  r_led, w_led_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic [1:0]  r_mode, w_mode_next;
  logic        r_dir_left, w_dir_left_next;

  logic        w_tick;
  logic [7:0]  w_step_led;
  logic        w_step_dir_left;
  logic        w_cycle_end;
  logic        w_last;

  function automatic logic [7:0] init_pat(input logic [1:0] md);
    case (md)
      2'd1:    return 8'h80;
      2'd3:    return 8'h00;
      default: return 8'h01;
    endcase
  endfunction

  assign w_tick = (r_state == S_RUN) && !io_bus.hold && (r_presc == DIV_M1);

  // Ping-pong direction flips only when the lit bit sits at either end.
  always_comb begin
    w_step_dir_left = r_dir_left;
    w_step_led      = r_led;
    case (r_mode)
      2'd0: w_step_led = {r_led[6:0], r_led[7]};
      2'd1: w_step_led = {r_led[0], r_led[7:1]};
      2'd2: begin
        if (r_led == 8'h80)      w_step_dir_left = 1'b0;
        else if (r_led == 8'h01) w_step_dir_left = 1'b1;
        w_step_led = w_step_dir_left ? {r_led[6:0], 1'b0} : {1'b0, r_led[7:1]};
      end
      default: w_step_led = r_led + 8'd1;
    endcase
  end

  assign w_cycle_end = (w_step_led == init_pat(r_mode));
  assign w_last      = w_cycle_end && (REP_L != 17'd0) && (({1'b0, r_rep} + 17'd1) == REP_L);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_state_next = S_RUN;
      S_RUN: begin
        if (io_bus.hold)          w_state_next = S_PAUSE;
        else if (w_tick && w_last) w_state_next = S_IDLE;
      end
      S_PAUSE: if (!io_bus.hold) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_presc_next    = r_presc;
    w_rep_next      = r_rep;
    w_led_next      = r_led;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_mode_next     = r_mode;
    w_dir_left_next = r_dir_left;
    case (r_state)
      S_IDLE: begin
        w_led_next  = 8'h00;
        w_busy_next = 1'b0;
        if (io_bus.start) begin
          w_mode_next     = io_bus.mode;
          w_led_next      = init_pat(io_bus.mode);
          w_busy_next     = 1'b1;
          w_presc_next    = 16'd0;
          w_rep_next      = 16'd0;
          w_dir_left_next = 1'b1;
        end
      end
      S_RUN: begin
        if (!io_bus.hold) begin
          if (w_tick) begin
            w_presc_next    = 16'd0;
            w_led_next      = w_step_led;
            w_dir_left_next = w_step_dir_left;
            if (w_cycle_end && (r_rep != 16'hFFFF)) w_rep_next = r_rep + 16'd1;
            if (w_last) begin
              w_led_next  = 8'h00;
              w_busy_next = 1'b0;
              w_done_next = 1'b1;
            end
          end else begin
            w_presc_next = r_presc + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_presc    <= 16'd0;
      r_rep      <= 16'd0;
      r_led      <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mode     <= 2'd0;
      r_dir_left <= 1'b1;
    end else begin
      r_presc    <= w_presc_next;
      r_rep      <= w_rep_next;
      r_led      <= w_led_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_mode     <= w_mode_next;
      r_dir_left <= w_dir_left_next;
    end
  end

  assign io_bus.LED8 = r_led;
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised self-checking bench for led_pattern_sequencer (DIV=4, REPEAT=2).
// The reference model tracks tick count per run and derives LED8 arithmetically.
module tb_led_pattern_sequencer;
  localparam int DIV    = 4;
  localparam int REPEAT = 2;

  logic clk;
  logic reset;
  led_pattern_sequencer_if bus();

  led_pattern_sequencer #(.DIV(DIV), .REPEAT(REPEAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: 0 idle, 1 run, 2 pause; m_k = ticks taken since the run began.
  int m_st = 0, m_mode = 0, m_k = 0, m_cnt = 0;
  bit m_done = 1'b0;

  function automatic int cyc_len(input int md);
    case (md)
      0, 1:    return 8;
      2:       return 14;
      default: return 256;
    endcase
  endfunction

  function automatic logic [7:0] pat(input int md, input int k);
    int p;
    case (md)
      0: begin p = k % 8; return 8'(1 << p); end
      1: begin p = k % 8; return 8'(128 >> p); end
      2: begin p = k % 14; return (p < 8) ? 8'(1 << p) : 8'(1 << (14 - p)); end
      default: return 8'(k % 256);
    endcase
  endfunction

  function automatic logic [9:0] exp_vec();
    return {(m_st == 0) ? 8'h00 : pat(m_mode, m_k), (m_st != 0), m_done};
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (!reset) begin
      m_st = 0; m_mode = 0; m_k = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: if (bus.start) begin m_st = 1; m_mode = int'(bus.mode); m_k = 0; m_cnt = 0; end
        1: begin
          if (bus.hold) m_st = 2;
          else if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_k++;
            if (REPEAT != 0 && m_k == REPEAT * cyc_len(m_mode)) begin
              m_st = 0; m_done = 1'b1;
            end
          end else m_cnt++;
        end
        default: if (!bus.hold) m_st = 1;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.mode = 2'($urandom);
      step();
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== 10'h000) begin
        n_err++;
        $display("FAIL reset_hold: LED8=%h busy=%b done=%b, want 00 0 0", bus.LED8, bus.busy, bus.done);
      end
    end
    bus.start = 1'b0; reset = 1'b1;
    step();
    n_vec++;
    if ({bus.LED8, bus.busy, bus.done} !== 10'h000) begin
      n_err++;
      $display("FAIL reset_release: LED8=%h busy=%b done=%b, want 00 0 0", bus.LED8, bus.busy, bus.done);
    end
  endtask

  task automatic test_mode0();
    int steps, dones;
    bus.mode = 2'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_vec++;
    if (bus.LED8 !== 8'h01 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL mode0_first: LED8=%h busy=%b, want 01 1", bus.LED8, bus.busy);
    end
    steps = 0; dones = 0;
    while (steps < 80 && !bus.done) begin
      step(); steps++;
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL mode0_seq: cyc=%0d got %h, want %h", steps, {bus.LED8, bus.busy, bus.done}, exp_vec());
      end
    end
    n_vec++;
    if (steps != 64 || bus.done !== 1'b1 || bus.LED8 !== 8'h00 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL mode0_done: after %0d clks done=%b LED8=%h busy=%b, want 64 clks 1 00 0", steps, bus.done, bus.LED8, bus.busy);
    end
    step();
    n_vec++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL mode0_done_pulse: done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_pingpong();
    int steps;
    bus.mode = 2'd2; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    steps = 0;
    while (steps < 130 && !bus.done) begin
      step(); steps++;
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL pingpong_seq: cyc=%0d got %h, want %h", steps, {bus.LED8, bus.busy, bus.done}, exp_vec());
      end
    end
    n_vec++;
    if (steps != REPEAT * 14 * DIV || bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL pingpong_done: done=%b after %0d clks, want 1 after %0d", bus.done, steps, REPEAT * 14 * DIV);
    end
  endtask

  task automatic test_hold();
    logic [7:0] frozen;
    int steps;
    bus.mode = 2'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    frozen = bus.LED8;
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if (bus.LED8 !== frozen || bus.busy !== 1'b1 || {bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL hold_freeze: LED8=%h busy=%b, want %h 1", bus.LED8, bus.busy, frozen);
      end
    end
    bus.hold = 1'b0;
    steps = 0;
    while (steps < 300 && !bus.done) begin
      step(); steps++;
      bus.hold = ($urandom_range(0, 4) == 0);
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL hold_random: cyc=%0d got %h, want %h", steps, {bus.LED8, bus.busy, bus.done}, exp_vec());
      end
    end
    bus.hold = 1'b0;
    n_vec++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL hold_timeout: done=%b, want 1 within 300 clks", bus.done);
    end
  endtask

  task automatic test_start_with_hold();
    bus.mode = 2'd3; bus.start = 1'b1; bus.hold = 1'b1;
    step();
    bus.start = 1'b0;
    n_vec++;
    if ({bus.LED8, bus.busy, bus.done} !== {8'h00, 1'b1, 1'b0} || m_st != 1) begin
      n_err++;
      $display("FAIL start_hold_enter: got %h, want %h", {bus.LED8, bus.busy, bus.done}, {8'h00, 1'b1, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL start_hold_pause: got %h, want %h", {bus.LED8, bus.busy, bus.done}, exp_vec());
      end
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int steps;
    bus.mode = 2'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    steps = 0;
    while (steps < 60 && pat(m_mode, m_k) != 8'h05) begin step(); steps++; end
    n_vec++;
    if (bus.LED8 !== 8'h05) begin
      n_err++;
      $display("FAIL midrun_reach: LED8=%h, want 05", bus.LED8);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_vec++;
    if ({bus.LED8, bus.busy, bus.done} !== 10'h000) begin
      n_err++;
      $display("FAIL midrun_reset: got %h, want 000", {bus.LED8, bus.busy, bus.done});
    end
    step();
    n_vec++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_after: done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_ignore_start_mode();
    int steps, dones;
    bus.mode = 2'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    steps = 0; dones = 0;
    while (steps < 80 && dones == 0) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mode  = 2'd3;
      step(); steps++;
      if (bus.done === 1'b1) dones++;
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL ignore_seq: cyc=%0d got %h, want %h", steps, {bus.LED8, bus.busy, bus.done}, exp_vec());
      end
    end
    bus.start = 1'b0;
    step();
    if (bus.done === 1'b1) dones++;
    n_vec++;
    if (dones != 1 || steps != 64) begin
      n_err++;
      $display("FAIL ignore_done: %0d done pulses at %0d clks, want 1 at 64", dones, steps);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.hold  = ($urandom_range(0, 4) == 0);
      bus.mode  = 2'($urandom);
      step();
      n_vec++;
      if ({bus.LED8, bus.busy, bus.done} !== exp_vec()) begin
        n_err++;
        $display("FAIL random: cyc=%0d got %h, want %h", i, {bus.LED8, bus.busy, bus.done}, exp_vec());
      end
    end
    reset = 1'b1; bus.start = 1'b0; bus.hold = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.hold = 1'b0; bus.mode = 2'd0; reset = 1'b0;
    test_reset();
    test_mode0();
    test_pingpong();
    test_hold();
    test_start_with_hold();
    test_reset_midrun();
    test_ignore_start_mode();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pattern step (tick); legal range 2..65535.
REQ-002 Parameter REPEAT, default 2: full pattern cycles per run; 0 = run until reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 hold  input  1  level; pauses the sequence while high.
REQ-007 mode  input  2  pattern select; latched on accepted start.
REQ-008 LED8  output  8  LED drive pattern, registered.
REQ-009 busy  output  1  high in RUN and PAUSE, registered.
REQ-010 done  output  1  one-cycle pulse at run completion, registered.

Function
REQ-011 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-012 IDLE->RUN on start=1; next edge sets LED8 to the mode's initial pattern, busy=1, prescaler=0 and repeat count=0.
REQ-013 start SHALL be ignored in RUN/PAUSE; mode changes SHALL be ignored while busy=1.
REQ-014 RUN->PAUSE when hold=1; PAUSE->RUN when hold=0; prescaler and LED8 SHALL freeze in any cycle with hold=1.
REQ-015 start=1 and hold=1 together in IDLE SHALL enter RUN; PAUSE follows on the next edge if hold is still 1.
REQ-016 Prescaler counts 0..DIV-1 only in RUN with hold=0; tick = (count==DIV-1); count wraps to 0 on tick.
REQ-017 Mode 0: initial 8'h01; each tick rotates left 1 bit; cycle = 8 ticks.
REQ-018 Mode 1: initial 8'h80; each tick rotates right 1 bit; cycle = 8 ticks.
REQ-019 Mode 2 (ping-pong): initial 8'h01; moves left to 8'h80, then right back to 8'h01; cycle = 14 ticks; direction reverses at 8'h80 and 8'h01, never at any other value.
REQ-020 Mode 3: initial 8'h00; each tick increments modulo 256 (8'hFF->8'h00); cycle = 256 ticks.
REQ-021 A cycle completes on the tick that returns LED8 to the initial pattern; the repeat count (16-bit, saturating) increments on that tick.
REQ-022 With REPEAT!=0, the tick that completes cycle REPEAT SHALL, on that edge, set state=IDLE, LED8=8'h00, busy=0 and done=1.
REQ-023 done SHALL be high for exactly one cycle; it is 0 at all other times.
REQ-024 With REPEAT=0, the block SHALL cycle indefinitely and done SHALL never assert.
REQ-025 LED8 SHALL be 8'h00 throughout IDLE.

Reset
REQ-026 When reset=0 at a clk edge, the block SHALL go to state=IDLE, LED8=8'h00, busy=0, done=0, prescaler=0, repeat count=0 and latched mode=0, in any state.
REQ-027 Reset mid-run SHALL abort without asserting done; the first start after reset releases behaves as in REQ-012.

Verification (DIV=4, REPEAT=2 unless stated)
REQ-028 Hold reset=0 for 2 cycles -> LED8=8'h00, busy=0, done=0; start pulses during reset are ignored.
REQ-029 mode=0, 1-cycle start pulse -> LED8=01, then 02 after 4 clks, ..., 80, 01; after 16 ticks (64 clks in RUN): done=1 for 1 cycle, LED8=00, busy=0.
REQ-030 mode=2, REPEAT=1 -> LED8 sequence 01,02,04,...,80,40,...,02,01 at 4-clk spacing; done after 14 ticks.
REQ-031 hold=1 for 10 cycles mid-step in mode 1 -> LED8 and prescaler frozen, busy=1; the step completes DIV minus the elapsed count cycles after hold=0.
REQ-032 mode=3, reset=0 when LED8=8'h05 -> next edge LED8=00, busy=0, done stays 0.
REQ-033 start re-pulsed and mode changed 0->3 during a mode-0 run -> no restart, pattern stays in rotate-left order, single done at the end.
